hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: drives stall (enable) and flush (bubble) controls of the
//  F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding mux selects. Owns the data-memory

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_if.sv | 21 ++
 rtl/hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
package riscv_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT,
        M_DONE
    } mem_state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESSRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - data-memory request handshake seen by the M stage
interface hazard_ctrl_if;
    logic MemRead_m;
    logic MemStore_m;
    logic dmem_req;
    logic dmem_ready;

    modport master (
        input  MemRead_m,
        input  MemStore_m,
        input  dmem_ready,
        output dmem_req
    );

    modport slave (
        output MemRead_m,
        output MemStore_m,
        output dmem_ready,
        input  dmem_req
    );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// rtl/hazard_ctrl_fwd_unit.sv - E-stage forwarding select for one source operand
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic       regWrite_m,
    input  logic [4:0] rd_w,
    input  logic       regWrite_w,
    output fwd_sel_t   fwd_sel
);

    // The youngest producer (M) wins over W; x0 is hardwired zero and never forwarded.
    always_comb begin
        fwd_sel = FWD_RF;
        if (regWrite_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_M;
        end else if (regWrite_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencing, forwarding selects and data-memory handshake FSM
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           rs1_d,
    input  logic [4:0]           rs2_d,
    input  logic [4:0]           rs1_e,
    input  logic [4:0]           rs2_e,
    input  logic [4:0]           rd_e,
    input  logic [1:0]           resultSrc_e,
    input  logic                 pcSrc_e,
    input  logic [4:0]           rd_m,
    input  logic                 regWrite_m,
    input  logic [4:0]           rd_w,
    input  logic                 regWrite_w,
    hazard_ctrl_if.master        mem,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_w,
    output logic [1:0]           forwardA_e,
    output logic [1:0]           forwardB_e,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int                WCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT_CYCLES);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t           state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic     mem_op;
    logic     req;
    logic     mem_stall;
    logic     load_use;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    assign mem_op = mem.MemRead_m | mem.MemStore_m;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        req       = 1'b0;
        unique case (state_q)
            M_IDLE: begin
                if (mem_op) begin
                    req = 1'b1;
                    if (mem.dmem_ready) begin
                        state_d = M_DONE;
                    end else begin
                        state_d = M_WAIT;
                        wcnt_d  = '0;
                    end
                end
            end
            M_WAIT: begin
                req = 1'b1;
                if (wcnt_q != WCNT_MAX) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                // Flag the slow access but keep waiting; the memory may still answer.
                if (wcnt_q >= WCNT_LAST) begin
                    timeout_d = 1'b1;
                end
                if (mem.dmem_ready) begin
                    state_d = M_DONE;
                end
            end
            M_DONE: begin
                state_d = M_IDLE;
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase
    end

    assign mem_stall = req & ~mem.dmem_ready;
    assign load_use  = (resultSrc_e == RESSRC_LOAD) && (rd_e != 5'd0) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));

    // A memory freeze holds every stage, so branch and load-use resolve once it lifts.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (pcSrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign stall_cnt_d = stall_cnt_q + CNT_WIDTH'(stall_f);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= M_IDLE;
            wcnt_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fwd_unit u_fwd_a (
        .rs_e       (rs1_e),
        .rd_m       (rd_m),
        .regWrite_m (regWrite_m),
        .rd_w       (rd_w),
        .regWrite_w (regWrite_w),
        .fwd_sel    (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs_e       (rs2_e),
        .rd_m       (rd_m),
        .regWrite_m (regWrite_m),
        .rd_w       (rd_w),
        .regWrite_w (regWrite_w),
        .fwd_sel    (fwd_b)
    );

    assign mem.dmem_req = req & ~rst;
    assign forwardA_e   = rst ? FWD_RF : fwd_a;
    assign forwardB_e   = rst ? FWD_RF : fwd_b;
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    localparam int T_OUT = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0]  resultSrc_e;
    logic        pcSrc_e, regWrite_m, regWrite_w;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_w;
    logic [1:0]  forwardA_e, forwardB_e;
    logic        mem_timeout;
    logic [31:0] stall_cycles;

    hazard_ctrl_if mif ();

    hazard_ctrl #(.TIMEOUT_CYCLES(T_OUT), .CNT_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_e         (rd_e),
        .resultSrc_e  (resultSrc_e),
        .pcSrc_e      (pcSrc_e),
        .rd_m         (rd_m),
        .regWrite_m   (regWrite_m),
        .rd_w         (rd_w),
        .regWrite_w   (regWrite_w),
        .mem          (mif),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_d      (flush_d),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .forwardA_e   (forwardA_e),
        .forwardB_e   (forwardB_e),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: an access is outstanding until acknowledged; the cycle after an ack issues nothing.
    bit          m_busy, m_done, m_to;
    int          m_wcnt;
    logic [31:0] m_scnt;
    bit          last_req, last_sf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rs != 0 && regWrite_m && rd_m == rs) return 2'b10;
        if (rs != 0 && regWrite_w && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic compare();
        bit mop, e_req, e_ms, lu;
        bit sf, sd, se, sm, fd, fe, fw;
        logic [1:0] fa, fb;
        #4;
        mop   = mif.MemRead_m || mif.MemStore_m;
        e_req = !rst && !m_done && (m_busy || mop);
        e_ms  = e_req && !mif.dmem_ready;
        lu    = resultSrc_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        {sf, sd, se, sm, fd, fe, fw} = '0;
        fa = rst ? 2'b00 : fwd_model(rs1_e);
        fb = rst ? 2'b00 : fwd_model(rs2_e);
        if (rst) {fd, fe, fw} = 3'b111;
        else if (e_ms) {sf, sd, se, sm, fw} = 5'b11111;
        else if (pcSrc_e) {fd, fe} = 2'b11;
        else if (lu) {sf, sd, fe} = 3'b111;
        chk("model stall_f", 32'(stall_f), 32'(sf));
        chk("model stall_d", 32'(stall_d), 32'(sd));
        chk("model stall_e", 32'(stall_e), 32'(se));
        chk("model stall_m", 32'(stall_m), 32'(sm));
        chk("model flush_d", 32'(flush_d), 32'(fd));
        chk("model flush_e", 32'(flush_e), 32'(fe));
        chk("model flush_w", 32'(flush_w), 32'(fw));
        chk("model forwardA_e", 32'(forwardA_e), 32'(fa));
        chk("model forwardB_e", 32'(forwardB_e), 32'(fb));
        chk("model dmem_req", 32'(mif.dmem_req), 32'(e_req));
        chk("model mem_timeout", 32'(mem_timeout), 32'(m_to));
        chk("model stall_cycles", stall_cycles, m_scnt);
        last_req = e_req;
        last_sf  = sf;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_done = 0; m_to = 0; m_wcnt = 0; m_scnt = 0;
        end else begin
            m_scnt = m_scnt + 32'(last_sf);
            if (m_busy) begin
                m_wcnt = (m_wcnt < T_OUT) ? m_wcnt + 1 : T_OUT;
                if (m_wcnt >= T_OUT) m_to = 1;
            end
            if (last_req && mif.dmem_ready) begin
                m_done = 1; m_busy = 0;
            end else if (last_req) begin
                if (!m_busy) m_wcnt = 0;
                m_busy = 1; m_done = 0;
            end else begin
                m_done = 0;
            end
        end
        #1;
    endtask

    task automatic quiet();
        rst = 0; rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        resultSrc_e = 0; pcSrc_e = 0; regWrite_m = 0; regWrite_w = 0;
        mif.MemRead_m = 0; mif.MemStore_m = 0; mif.dmem_ready = 0;
    endtask

    initial begin
        quiet();
        rst = 1;
        @(posedge clk);
        #1;
        m_busy = 0; m_done = 0; m_to = 0; m_wcnt = 0; m_scnt = 0;

        // Reset with a memory op pending
        mif.MemRead_m = 1;
        for (int i = 0; i < 2; i++) begin
            compare();
            chk("rst dmem_req", 32'(mif.dmem_req), 0);
            chk("rst flush_dew", 32'({flush_d, flush_e, flush_w}), 32'h7);
            tick();
        end
        rst = 0; mif.MemRead_m = 0;
        compare();
        chk("post-rst stall_cycles", stall_cycles, 0);
        tick();
        mif.MemRead_m = 1; mif.dmem_ready = 1;
        compare();
        chk("idle 1-cycle req", 32'(mif.dmem_req), 1);
        chk("idle 1-cycle no stall", 32'(stall_f), 0);
        tick();
        compare();
        chk("done no req", 32'(mif.dmem_req), 0);
        tick();
        quiet();

        // Load-use
        resultSrc_e = 2'b01; rd_e = 5; rs1_d = 5;
        compare();
        chk("load-use stalls", 32'({stall_f, stall_d, flush_e, flush_d}), 32'hE);
        tick();
        rd_e = 0;
        compare();
        chk("x0 load no stall", 32'({stall_f, flush_e}), 0);
        tick();
        quiet();

        // Forwarding
        rd_m = 7; rd_w = 7; regWrite_m = 1; regWrite_w = 1; rs1_e = 7; rs2_e = 0;
        compare();
        chk("fwdA from M", 32'(forwardA_e), 32'h2);
        chk("fwdB x0", 32'(forwardB_e), 0);
        tick();
        regWrite_m = 0;
        compare();
        chk("fwdA from W", 32'(forwardA_e), 32'h1);
        tick();
        quiet();

        // Multi-cycle load
        mif.MemRead_m = 1;
        for (int i = 0; i < 4; i++) begin
            mif.dmem_ready = (i == 3);
            compare();
            chk("wait dmem_req", 32'(mif.dmem_req), 1);
            chk("wait stall pattern", 32'({stall_f, stall_d, stall_e, stall_m, flush_w}),
                (i < 3) ? 32'h1F : 32'h0);
            tick();
        end
        mif.MemRead_m = 0; mif.dmem_ready = 0;
        compare();
        chk("after wait no req", 32'(mif.dmem_req), 0);
        chk("stall_cycles after wait", stall_cycles, 4);
        tick();

        // Priority: branch beats load-use, memory freeze beats both
        resultSrc_e = 2'b01; rd_e = 9; rs2_d = 9; pcSrc_e = 1;
        compare();
        chk("branch over load-use", 32'({flush_d, flush_e, stall_f}), 32'h6);
        tick();
        mif.MemStore_m = 1;
        for (int i = 0; i < 2; i++) begin
            compare();
            chk("mem over branch", 32'({stall_f, flush_d, flush_e, flush_w}), 32'h9);
            tick();
        end
        mif.dmem_ready = 1;
        compare();
        tick();
        quiet();
        compare();
        tick();

        // Timeout
        mif.MemRead_m = 1;
        for (int i = 0; i < 6; i++) begin
            compare();
            chk("timeout timing", 32'(mem_timeout), (i >= 5) ? 1 : 0);
            tick();
        end
        mif.dmem_ready = 1;
        compare();
        tick();
        quiet();
        compare();
        chk("timeout sticky", 32'(mem_timeout), 1);
        tick();
        rst = 1;
        compare();
        tick();
        rst = 0;
        compare();
        chk("timeout cleared", 32'(mem_timeout), 0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            rs1_d         = 5'($urandom_range(0, 3));
            rs2_d         = 5'($urandom_range(0, 3));
            rs1_e         = 5'($urandom_range(0, 3));
            rs2_e         = 5'($urandom_range(0, 3));
            rd_e          = 5'($urandom_range(0, 3));
            rd_m          = 5'($urandom_range(0, 3));
            rd_w          = 5'($urandom_range(0, 3));
            resultSrc_e   = 2'($urandom_range(0, 3));
            pcSrc_e       = ($urandom_range(0, 7) == 0);
            regWrite_m    = 1'($urandom_range(0, 1));
            regWrite_w    = 1'($urandom_range(0, 1));
            mif.MemRead_m = ($urandom_range(0, 3) == 0);
            mif.MemStore_m = ($urandom_range(0, 5) == 0);
            mif.dmem_ready = ($urandom_range(0, 2) == 0);
            compare();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
